// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - request/response bus between a requester and the data-memory controller
interface data_mem_ctrl_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        misaligned;

    modport master (
        output req, we, size, unsigned_ld, addr, wdata,
        input  rdata, ready, misaligned
    );

    modport slave (
        input  req, we, size, unsigned_ld, addr, wdata,
        output rdata, ready, misaligned
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - word-organised data RAM executing big-endian MIPS byte/half/word loads and stores
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           reset,
    data_mem_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          mis_q, mis_d;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          idle;
    logic          a_we;
    logic [1:0]    a_size;
    logic          a_uns;
    logic [AW+1:0] a_addr;
    logic [31:0]   a_wdata;
    logic [AW-1:0] word_idx;
    logic [31:0]   word_old;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_val;
    logic [31:0]   store_val;
    logic          fault;
    logic          commit;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^bus.addr[31:AW+2];

    // With WAIT_CYCLES=0 the commit edge is the sampling edge, so the access
    // fields must come straight from the bus rather than from the latches.
    assign idle    = (state_q == S_IDLE);
    assign a_we    = idle ? bus.we          : we_q;
    assign a_size  = idle ? bus.size        : size_q;
    assign a_uns   = idle ? bus.unsigned_ld : uns_q;
    assign a_addr  = idle ? bus.addr[AW+1:0] : addr_q;
    assign a_wdata = idle ? bus.wdata       : wdata_q;

    assign word_idx = a_addr[AW+1:2];
    assign word_old = mem_q[word_idx];

    assign commit = !reset &&
                    (((state_q == S_WAIT) && (cnt_q == 4'd0)) ||
                     (idle && bus.req && NO_WAIT));

    always_comb begin
        fault = 1'b0;
        case (a_size)
            2'b00:   fault = 1'b0;
            2'b01:   fault = a_addr[0];
            default: fault = (a_addr[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        byte_sel = word_old[7:0];
        case (a_addr[1:0])
            2'd0:    byte_sel = word_old[31:24];
            2'd1:    byte_sel = word_old[23:16];
            2'd2:    byte_sel = word_old[15:8];
            default: byte_sel = word_old[7:0];
        endcase
        half_sel = a_addr[1] ? word_old[15:0] : word_old[31:16];

        load_val = word_old;
        case (a_size)
            2'b00:   load_val = {{24{byte_sel[7] & ~a_uns}}, byte_sel};
            2'b01:   load_val = {{16{half_sel[15] & ~a_uns}}, half_sel};
            default: load_val = word_old;
        endcase
    end

    // Partial stores merge into the current word so untouched lanes survive.
    always_comb begin
        store_val = a_wdata;
        case (a_size)
            2'b00: begin
                store_val = word_old;
                case (a_addr[1:0])
                    2'd0:    store_val[31:24] = a_wdata[7:0];
                    2'd1:    store_val[23:16] = a_wdata[7:0];
                    2'd2:    store_val[15:8]  = a_wdata[7:0];
                    default: store_val[7:0]   = a_wdata[7:0];
                endcase
            end
            2'b01: begin
                store_val = word_old;
                if (a_addr[1]) store_val[15:0]  = a_wdata[15:0];
                else           store_val[31:16] = a_wdata[15:0];
            end
            default: store_val = a_wdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    if (NO_WAIT) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        mis_d   = 1'b0;
        if (commit) begin
            mis_d = fault;
            if (fault)      rdata_d = 32'd0;
            else if (!a_we) rdata_d = load_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            if (idle && bus.req) begin
                we_q    <= bus.we;
                size_q  <= bus.size;
                uns_q   <= bus.unsigned_ld;
                addr_q  <= bus.addr[AW+1:0];
                wdata_q <= bus.wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && a_we && !fault) begin
            mem_q[word_idx] <= store_val;
        end
    end

    assign bus.rdata      = rdata_q;
    assign bus.ready      = (state_q == S_RESP);
    assign bus.misaligned = mis_q;
endmodule
